l2_line_state_array: RTL and testbench
======================================

// Module: l2_line_state_array
// PURPOSE
//  Per-line valid/dirty status store for the L2 cache, shared by PORTS cache-controller
//  channels (port 0 = inst, port 1 = data by default).
//  Adds a built-in flush engine: walks every line, hands dirty lines to the write-back
//  path over a req/ack handshake, and leaves the array fully invalid and clean.
// PARAMETERS
//  LINES  128  number of cache lines tracked (power of 2, >=2)
//  PORTS  2    number of update/lookup channels (>=1)
//  IDX_W  $clog2(LINES)  derived line-index width; never overridden
// PORTS
//  clk        in   1            rising-edge clock
//  rst        in   1            synchronous reset, active-high
//  idx        in   PORTS*IDX_W  per-port line index; port p uses bits [p*IDX_W +: IDX_W]
//  valid_set  in   PORTS        set valid[idx_p]
//  dirty_set  in   PORTS        set dirty[idx_p]
//  dirty_clr  in   PORTS        clear dirty[idx_p]
//  inval      in   PORTS        clear valid[idx_p] and dirty[idx_p]
//  valid_o    out  PORTS        valid[idx_p], combinational read of current state
//  dirty_o    out  PORTS        dirty[idx_p], combinational read of current state
//  flush_req  in   1            start flush; sampled only in IDLE
//  flush_busy out  1            flush in progress; port updates are ignored while high
//  flush_done out  1            one-cycle pulse when flush completes
//  wb_req     out  1            dirty line awaiting write-back
//  wb_idx     out  IDX_W        index of the line under write-back
//  wb_ack     in   1            write-back accepted; meaningful only while wb_req=1
//  dirty_cnt  out  $clog2(LINES+1)  number of dirty lines (L2_DIRTY_CNT_EN only)
// BEHAVIOUR
//  Reset: valid/dirty arrays all 0; state IDLE; flush_busy=0, flush_done=0, wb_req=0,
//   wb_idx=0, dirty_cnt=0. Reset mid-flush aborts the flush with no done pulse.
//  Reads: valid_o/dirty_o are zero-latency. An update becomes visible the cycle after its edge.
//  Updates (IDLE only), resolved per line across all ports in the same cycle:
//   - Set beats clear: any valid_set wins over any inval.
//   - Any dirty_set wins over any dirty_clr/inval.
//   - dirty_set does not imply valid. Several ports may hit the same line; the result is the
//     OR of sets, then the OR of clears masked by the sets.
//  FSM IDLE->SCAN->(WB)->...->DONE->IDLE; ptr is an IDX_W-bit line pointer.
//   - IDLE: if flush_req, go to SCAN with ptr=0 and flush_busy=1 from the next cycle.
//   - SCAN: if dirty[ptr]=0, clear valid[ptr] and advance ptr (1 cycle per clean line).
//     If dirty[ptr]=1, go to WB.
//   - WB: wb_req=1 and wb_idx=ptr, both held stable until wb_ack. On the ack cycle, clear
//     valid[ptr] and dirty[ptr], advance ptr, and return to SCAN.
//   - The exit from SCAN/WB at ptr=LINES-1 goes to DONE, not SCAN. ptr never wraps mid-flush.
//   - DONE: flush_done=1 for exactly one cycle with flush_busy=0, then IDLE.
//  flush_req while busy or in DONE is ignored (not queued).
//  wb_ack outside WB is ignored.
//  flush_busy is high in SCAN and WB only.
//  All-clean flush: busy for exactly LINES cycles, then the done pulse.
//  wb_req drops the cycle after the ack cycle.
// CONFIGURATION
//  L2_DIRTY_CNT_EN defined: the dirty_cnt port exists. It is a register equal to the
//   popcount of the dirty array after each edge, so it tracks simultaneous multi-port
//   changes exactly. It is 0 after reset and 0 in the DONE cycle.
//  L2_DIRTY_CNT_EN undefined: the dirty_cnt port and its logic are absent; all other
//   behaviour is identical.
// TESTING
//  1) Port0 valid_set idx=5, port1 dirty_set idx=5 in one cycle -> next cycle
//     valid_o[0]=dirty_o[1]=1 at idx 5; dirty_cnt=1.
//  2) Same cycle: port0 inval idx=9, port1 valid_set+dirty_set idx=9 -> valid=1, dirty=1
//     (set wins).
//  3) LINES=128, all lines clean, flush_req pulse -> busy for 128 cycles, one flush_done
//     pulse, wb_req never asserted, all valid_o=0.
//  4) Lines 3 and 127 dirty; hold wb_ack low 4 cycles at each -> wb_req/wb_idx=3 stable
//     until ack, then wb_idx=127. Done pulse follows line 127. Final dirty_cnt=0.
//  5) While busy, port dirty_set idx=0 and a second flush_req -> both ignored; idx 0 stays
//     clean; exactly one done pulse.
//  6) rst asserted while in WB at ptr=40 -> next cycle IDLE, wb_req=0, no flush_done,
//     arrays all 0.

Source files
------------

// File: rtl/l2_line_state_array.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | l2_line_state_array: per-line valid/dirty store with a built-in flush       |
// | engine that writes back dirty lines and leaves the array invalid and clean. |
// | Optional macro L2_DIRTY_CNT_EN adds the registered dirty_cnt popcount port. |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module l2_line_state_array #(
  parameter int LINES = 128,
  parameter int PORTS = 2,
  parameter int IDX_W = $clog2(LINES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PORTS*IDX_W-1:0] idx,
  input  logic [PORTS-1:0]       valid_set,
  input  logic [PORTS-1:0]       dirty_set,
  input  logic [PORTS-1:0]       dirty_clr,
  input  logic [PORTS-1:0]       inval,
  output logic [PORTS-1:0]       valid_o,
  output logic [PORTS-1:0]       dirty_o,
  input  logic                   flush_req,
  output logic                   flush_busy,
  output logic                   flush_done,
  output logic                   wb_req,
  output logic [IDX_W-1:0]       wb_idx,
  input  logic                   wb_ack
`ifdef L2_DIRTY_CNT_EN
  ,
  output logic [$clog2(LINES+1)-1:0] dirty_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_WB   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [LINES-1:0] valid_q, valid_d;
  logic [LINES-1:0] dirty_q, dirty_d;
  logic [LINES-1:0] vset, vclr, dset, dclr;
  logic             ptr_last;

  // Per-line OR of every port's set and clear requests.
  always_comb begin
    vset = '0;
    vclr = '0;
    dset = '0;
    dclr = '0;
    for (int p = 0; p < PORTS; p++) begin
      vset[idx[p*IDX_W +: IDX_W]] = vset[idx[p*IDX_W +: IDX_W]] | valid_set[p];
      vclr[idx[p*IDX_W +: IDX_W]] = vclr[idx[p*IDX_W +: IDX_W]] | inval[p];
      dset[idx[p*IDX_W +: IDX_W]] = dset[idx[p*IDX_W +: IDX_W]] | dirty_set[p];
      dclr[idx[p*IDX_W +: IDX_W]] = dclr[idx[p*IDX_W +: IDX_W]] | dirty_clr[p] | inval[p];
    end
  end

  assign ptr_last = (ptr_q == IDX_W'(LINES - 1));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    case (state_q)
      ST_IDLE: begin
        // Sets win over clears when several ports hit the same line.
        valid_d = (valid_q & ~(vclr & ~vset)) | vset;
        dirty_d = (dirty_q & ~(dclr & ~dset)) | dset;
        if (flush_req) begin
          state_d = ST_SCAN;
          ptr_d   = '0;
        end
      end
      ST_SCAN: begin
        if (dirty_q[ptr_q]) begin
          state_d = ST_WB;
        end else begin
          valid_d[ptr_q] = 1'b0;
          if (ptr_last) begin
            state_d = ST_DONE;
          end else begin
            ptr_d = ptr_q + IDX_W'(1);
          end
        end
      end
      ST_WB: begin
        if (wb_ack) begin
          valid_d[ptr_q] = 1'b0;
          dirty_d[ptr_q] = 1'b0;
          if (ptr_last) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SCAN;
            ptr_d   = ptr_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  assign flush_busy = (state_q == ST_SCAN) || (state_q == ST_WB);
  assign flush_done = (state_q == ST_DONE);
  assign wb_req     = (state_q == ST_WB);
  assign wb_idx     = ptr_q;

  generate
    for (genvar p = 0; p < PORTS; p++) begin : g_rd
      assign valid_o[p] = valid_q[idx[p*IDX_W +: IDX_W]];
      assign dirty_o[p] = dirty_q[idx[p*IDX_W +: IDX_W]];
    end
  endgenerate

`ifdef L2_DIRTY_CNT_EN
  localparam int CNT_W = $clog2(LINES + 1);

  logic [CNT_W-1:0] dirty_cnt_q, dirty_cnt_d;

  // Popcount of the next-state array so the count lands on the same edge.
  always_comb begin
    dirty_cnt_d = '0;
    for (int l = 0; l < LINES; l++) begin
      dirty_cnt_d = dirty_cnt_d + CNT_W'(dirty_d[l]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dirty_cnt_q <= '0;
    end else begin
      dirty_cnt_q <= dirty_cnt_d;
    end
  end

  assign dirty_cnt = dirty_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_l2_line_state_array.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_l2_line_state_array: randomized bench for l2_line_state_array against a  |
// | line-level reference model. Honours L2_DIRTY_CNT_EN when defined.           |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_l2_line_state_array;
  localparam int LINES = 128;
  localparam int PORTS = 2;
  localparam int IDX_W = 7;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [PORTS*IDX_W-1:0] idx;
  logic [PORTS-1:0]       valid_set, dirty_set, dirty_clr, inval;
  logic [PORTS-1:0]       valid_o, dirty_o;
  logic                   flush_req, flush_busy, flush_done, wb_req, wb_ack;
  logic [IDX_W-1:0]       wb_idx;
`ifdef L2_DIRTY_CNT_EN
  logic [7:0]             dirty_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  bit mv[LINES];
  bit md[LINES];
  int ix[PORTS];

  always #5 clk = ~clk;

  l2_line_state_array #(.LINES(LINES), .PORTS(PORTS)) dut (
    .clk(clk), .rst(rst), .idx(idx),
    .valid_set(valid_set), .dirty_set(dirty_set), .dirty_clr(dirty_clr), .inval(inval),
    .valid_o(valid_o), .dirty_o(dirty_o),
    .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done),
    .wb_req(wb_req), .wb_idx(wb_idx), .wb_ack(wb_ack)
`ifdef L2_DIRTY_CNT_EN
    , .dirty_cnt(dirty_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idx();
    for (int p = 0; p < PORTS; p++) idx[p*IDX_W +: IDX_W] = IDX_W'(ix[p]);
  endtask

  task automatic idle_inputs();
    valid_set = '0; dirty_set = '0; dirty_clr = '0; inval = '0;
    flush_req = 1'b0; wb_ack = 1'b0;
  endtask

  function automatic int popcnt();
    int n = 0;
    for (int l = 0; l < LINES; l++) n += int'(md[l]);
    return n;
  endfunction

  // Line-level rule: any set makes the bit 1, otherwise any clear makes it 0.
  task automatic model_update();
    for (int q = 0; q < PORTS; q++) begin
      int l;
      bit sv, cv, sd, cd;
      l = ix[q]; sv = 0; cv = 0; sd = 0; cd = 0;
      for (int p = 0; p < PORTS; p++) begin
        if (ix[p] == l) begin
          sv |= valid_set[p]; cv |= inval[p];
          sd |= dirty_set[p]; cd |= dirty_clr[p] | inval[p];
        end
      end
      if (sv) mv[l] = 1; else if (cv) mv[l] = 0;
      if (sd) md[l] = 1; else if (cd) md[l] = 0;
    end
  endtask

  task automatic clear_model();
    for (int l = 0; l < LINES; l++) begin mv[l] = 0; md[l] = 0; end
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    clear_model();
  endtask

  task automatic set_line(input int l, input bit v, input bit d);
    idle_inputs();
    ix[0] = l; ix[1] = l;
    drive_idx();
    valid_set[0] = v; dirty_set[0] = d;
    model_update();
    tick();
    idle_inputs();
  endtask

  task automatic check_arrays(input string name);
    int bad = 0;
    int bl = 0;
    logic [3:0] got, exp;
    got = '0; exp = '0;
    idle_inputs();
    for (int l = 0; l < LINES; l++) begin
      ix[0] = l; ix[1] = LINES - 1 - l;
      drive_idx();
      #1;
      if ({valid_o[1], dirty_o[1], valid_o[0], dirty_o[0]} !==
          {mv[LINES-1-l], md[LINES-1-l], mv[l], md[l]}) begin
        if (bad == 0) begin
          bl = l;
          got = {valid_o[1], dirty_o[1], valid_o[0], dirty_o[0]};
          exp = {mv[LINES-1-l], md[LINES-1-l], mv[l], md[l]};
        end
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s: %0d bad lines, first at %0d got %b expected %b", name, bad, bl, got, exp);
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks++; if (flush_busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b expected 0", flush_busy); end
    do_reset();
    checks++; if (flush_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", flush_busy); end
    checks++; if (flush_done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", flush_done); end
    checks++; if (wb_req !== 1'b0) begin failures++; $display("FAIL reset_wb_req: got %b expected 0", wb_req); end
    checks++; if (wb_idx !== '0) begin failures++; $display("FAIL reset_wb_idx: got %0d expected 0", wb_idx); end
`ifdef L2_DIRTY_CNT_EN
    checks++; if (dirty_cnt !== 8'd0) begin failures++; $display("FAIL reset_cnt: got %0d expected 0", dirty_cnt); end
`endif
    check_arrays("reset_arrays");
  endtask

  task automatic test_same_line();
    do_reset();
    ix[0] = 5; ix[1] = 5; drive_idx();
    valid_set = 2'b01; dirty_set = 2'b10;
    model_update(); tick(); idle_inputs();
    checks++; if (valid_o[0] !== 1'b1) begin failures++; $display("FAIL same5_valid: got %b expected 1", valid_o[0]); end
    checks++; if (dirty_o[1] !== 1'b1) begin failures++; $display("FAIL same5_dirty: got %b expected 1", dirty_o[1]); end
`ifdef L2_DIRTY_CNT_EN
    checks++; if (dirty_cnt !== 8'd1) begin failures++; $display("FAIL same5_cnt: got %0d expected 1", dirty_cnt); end
`endif
    ix[0] = 9; ix[1] = 9; drive_idx();
    inval = 2'b01; valid_set = 2'b10; dirty_set = 2'b10;
    model_update(); tick(); idle_inputs();
    checks++; if ({valid_o[0], dirty_o[0]} !== 2'b11) begin failures++; $display("FAIL set_beats_inval: got %b expected 11", {valid_o[0], dirty_o[0]}); end
`ifdef L2_DIRTY_CNT_EN
    checks++; if (dirty_cnt !== 8'd2) begin failures++; $display("FAIL same9_cnt: got %0d expected 2", dirty_cnt); end
`endif
  endtask

  task automatic test_random_updates(input int n);
    for (int i = 0; i < n; i++) begin
      for (int p = 0; p < PORTS; p++) begin
        ix[p] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, LINES - 1)) : int'($urandom_range(0, 7));
        valid_set[p] = ($urandom_range(0, 2) == 0);
        dirty_set[p] = ($urandom_range(0, 2) == 0);
        dirty_clr[p] = ($urandom_range(0, 2) == 0);
        inval[p]     = ($urandom_range(0, 3) == 0);
      end
      drive_idx();
      #1;
      for (int p = 0; p < PORTS; p++) begin
        checks++;
        if ({valid_o[p], dirty_o[p]} !== {mv[ix[p]], md[ix[p]]}) begin
          failures++;
          $display("FAIL rand_read p%0d line %0d: got %b expected %b", p, ix[p], {valid_o[p], dirty_o[p]}, {mv[ix[p]], md[ix[p]]});
        end
      end
      model_update();
      tick();
`ifdef L2_DIRTY_CNT_EN
      checks++; if (dirty_cnt !== 8'(popcnt())) begin failures++; $display("FAIL rand_cnt: got %0d expected %0d", dirty_cnt, popcnt()); end
`endif
    end
    idle_inputs();
  endtask

  // Flush with a write-back agent: random holds (4 cycles at lines 3 and 127), random acks outside WB.
  task automatic run_flush(input bit inject, input string tag);
    int q[$];
    int hold[$];
    int exp_busy, busy_cyc, done_cnt, post, qi, hold_left, cur;
    bit acked_prev, in_wb;
    exp_busy = LINES; busy_cyc = 0; done_cnt = 0; post = 0; qi = 0; hold_left = 0; cur = -1;
    acked_prev = 0; in_wb = 0;
    for (int l = 0; l < LINES; l++) begin
      if (md[l]) begin
        int h;
        h = (l == 3 || l == 127) ? 4 : int'($urandom_range(0, 3));
        q.push_back(l); hold.push_back(h);
        exp_busy += h + 1;
      end
    end
    idle_inputs();
    flush_req = 1'b1;
    tick();
    for (int cyc = 0; cyc < LINES * 10 && post < 4; cyc++) begin
      idle_inputs();
      if (flush_busy) busy_cyc++;
      if (flush_done) begin
        done_cnt++;
        checks++; if (flush_busy !== 1'b0) begin failures++; $display("FAIL %s done_busy: got %b expected 0", tag, flush_busy); end
`ifdef L2_DIRTY_CNT_EN
        checks++; if (dirty_cnt !== 8'd0) begin failures++; $display("FAIL %s done_cnt: got %0d expected 0", tag, dirty_cnt); end
`endif
        flush_req = 1'b1;
      end else if (done_cnt > 0) begin
        post++;
        checks++;
        if ({flush_busy, wb_req} !== 2'b00) begin failures++; $display("FAIL %s after_done: busy/wb_req got %b expected 00", tag, {flush_busy, wb_req}); end
      end
      if (acked_prev) begin
        checks++; if (wb_req !== 1'b0) begin failures++; $display("FAIL %s wb_drop: got %b expected 0", tag, wb_req); end
        acked_prev = 0;
      end
      if (wb_req) begin
        checks++;
        if (!in_wb) begin
          in_wb = 1;
          if (qi >= q.size()) begin
            failures++; $display("FAIL %s wb_order: got idx %0d expected no write-back", tag, wb_idx);
            hold_left = 0;
          end else begin
            if (wb_idx !== IDX_W'(q[qi])) begin failures++; $display("FAIL %s wb_order: got %0d expected %0d", tag, wb_idx, q[qi]); end
            hold_left = hold[qi];
          end
          cur = int'(wb_idx);
        end else if (wb_idx !== IDX_W'(cur)) begin
          failures++; $display("FAIL %s wb_stable: got %0d expected %0d", tag, wb_idx, cur);
        end
        if (hold_left == 0) begin
          wb_ack = 1'b1; acked_prev = 1; in_wb = 0; qi++;
        end else begin
          hold_left--;
        end
      end else begin
        wb_ack = 1'($urandom_range(0, 1));
      end
      if (inject && flush_busy && busy_cyc == 10) begin
        ix[0] = 0; ix[1] = 100; drive_idx();
        dirty_set = 2'b11; valid_set = 2'b10; flush_req = 1'b1;
      end
      tick();
    end
    idle_inputs();
    checks++; if (busy_cyc != exp_busy) begin failures++; $display("FAIL %s busy_cycles: got %0d expected %0d", tag, busy_cyc, exp_busy); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL %s done_pulses: got %0d expected 1", tag, done_cnt); end
    checks++; if (qi != q.size()) begin failures++; $display("FAIL %s wb_count: got %0d expected %0d", tag, qi, q.size()); end
    checks++; if (post < 4) begin failures++; $display("FAIL %s timeout: post-done cycles got %0d expected 4", tag, post); end
    clear_model();
    check_arrays({tag, "_arrays"});
  endtask

  task automatic test_flush_clean();
    do_reset();
    for (int i = 0; i < 20; i++) set_line(int'($urandom_range(0, LINES - 1)), 1'b1, 1'b0);
    run_flush(1'b1, "flush_clean");
  endtask

  task automatic test_flush_dirty();
    do_reset();
    set_line(3, 1'b1, 1'b1);
    set_line(127, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++)
      set_line(int'($urandom_range(0, LINES - 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
`ifdef L2_DIRTY_CNT_EN
    checks++; if (dirty_cnt !== 8'(popcnt())) begin failures++; $display("FAIL pre_flush_cnt: got %0d expected %0d", dirty_cnt, popcnt()); end
`endif
    run_flush(1'b0, "flush_dirty");
  endtask

  task automatic test_back_to_back();
    test_random_updates(150);
    run_flush(1'b0, "flush_b2b");
    run_flush(1'b0, "flush_empty");
  endtask

  task automatic test_reset_mid_flush();
    bit found;
    found = 0;
    do_reset();
    set_line(40, 1'b1, 1'b1);
    set_line(41, 1'b1, 1'b0);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      if (wb_req) found = 1; else tick();
    end
    checks++; if (!found || wb_idx !== IDX_W'(40)) begin failures++; $display("FAIL midrst_reach_wb: got req=%b idx=%0d expected req=1 idx=40", wb_req, wb_idx); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({wb_req, flush_busy, flush_done} !== 3'b000) begin
      failures++; $display("FAIL midrst_outputs: req/busy/done got %b expected 000", {wb_req, flush_busy, flush_done});
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if ({flush_busy, flush_done} !== 2'b00) begin failures++; $display("FAIL midrst_idle: busy/done got %b expected 00", {flush_busy, flush_done}); end
    end
`ifdef L2_DIRTY_CNT_EN
    checks++; if (dirty_cnt !== 8'd0) begin failures++; $display("FAIL midrst_cnt: got %0d expected 0", dirty_cnt); end
`endif
    clear_model();
    check_arrays("midrst_arrays");
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    ix[0] = 0; ix[1] = 0;
    drive_idx();
    test_reset();
    test_same_line();
    test_random_updates(400);
    test_flush_clean();
    test_flush_dirty();
    test_back_to_back();
    test_reset_mid_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
